// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control,
// selectable rounding (nearest-even / toward zero), flush-to-zero inputs and
// per-result plus sticky exception flags {invalid, overflow, underflow, inexact}.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic                 rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out,
    output logic [3:0]           flags_now,
    output logic [3:0]           flags,
    input  logic                 flag_clr
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned PW   = 2 * MAN_W + 2;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (1 << EXP_W) - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    logic accept;

    // Stage 1 registers: classification, biased exponent sum, raw product
    logic          s1_valid_q, s1_valid_d;
    logic          s1_sign_q,  s1_sign_d;
    logic          s1_nan_q,   s1_nan_d;
    logic          s1_inv_q,   s1_inv_d;
    logic          s1_inf_q,   s1_inf_d;
    logic          s1_zero_q,  s1_zero_d;
    logic          s1_rm_q,    s1_rm_d;
    logic [EW-1:0] s1_exp_q,   s1_exp_d;
    logic [PW-1:0] s1_prod_q,  s1_prod_d;

    // Stage 2 registers: rounded exponent/mantissa and range flags
    logic             s2_valid_q, s2_valid_d;
    logic             s2_sign_q,  s2_sign_d;
    logic             s2_nan_q,   s2_nan_d;
    logic             s2_inv_q,   s2_inv_d;
    logic             s2_inf_q,   s2_inf_d;
    logic             s2_zero_q,  s2_zero_d;
    logic             s2_rm_q,    s2_rm_d;
    logic             s2_ovf_q,   s2_ovf_d;
    logic             s2_unf_q,   s2_unf_d;
    logic             s2_inx_q,   s2_inx_d;
    logic [EXP_W-1:0] s2_exp_q,   s2_exp_d;
    logic [MAN_W-1:0] s2_man_q,   s2_man_d;

    // Stage 3 / output registers
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_q,       out_d;
    logic [3:0]   flags_now_q, flags_now_d;
    logic [3:0]   flags_q,     flags_d;

    // Operand decode
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inf_x_zero;

    // Normalise / round datapath
    logic [PW-1:0]    norm;
    logic [EW-1:0]    exp_n, exp_r;
    logic [MAN_W-1:0] frac;
    logic             rnd_g, rnd_r, rnd_s, rnd_inc;
    logic [MAN_W:0]   man_sum;
    logic             ovf_c, unf_c;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    assign exp_a = A[W-2:MAN_W];
    assign exp_b = B[W-2:MAN_W];
    assign man_a = A[MAN_W-1:0];
    assign man_b = B[MAN_W-1:0];

    // Subnormals are flushed: any zero exponent counts as zero
    assign a_zero     = (exp_a == '0);
    assign b_zero     = (exp_b == '0);
    assign a_inf      = (exp_a == '1) && (man_a == '0);
    assign b_inf      = (exp_b == '1) && (man_b == '0);
    assign a_nan      = (exp_a == '1) && (man_a != '0);
    assign b_nan      = (exp_b == '1) && (man_b != '0);
    assign inf_x_zero = (a_inf && b_zero) || (b_inf && a_zero);

    assign norm    = s1_prod_q[PW-1] ? s1_prod_q : (s1_prod_q << 1);
    assign exp_n   = s1_exp_q + EW'(s1_prod_q[PW-1]);
    assign frac    = norm[2*MAN_W -: MAN_W];
    assign rnd_g   = norm[MAN_W];
    assign rnd_r   = norm[MAN_W-1];
    assign rnd_s   = |norm[MAN_W-2:0];
    assign rnd_inc = !s1_rm_q && rnd_g && (rnd_r || rnd_s || frac[0]);
    assign man_sum = {1'b0, frac} + (MAN_W+1)'(rnd_inc);
    assign exp_r   = exp_n + EW'(man_sum[MAN_W]);
    assign ovf_c   = !exp_r[EW-1] && (exp_r >= EW'(EMAX));
    assign unf_c   = exp_r[EW-1] || (exp_r == '0);

    // Stage 1: unpack, classify, exponent add, mantissa multiply
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_nan_d   = s1_nan_q;
        s1_inv_d   = s1_inv_q;
        s1_inf_d   = s1_inf_q;
        s1_zero_d  = s1_zero_q;
        s1_rm_d    = s1_rm_q;
        s1_exp_d   = s1_exp_q;
        s1_prod_d  = s1_prod_q;
        if (adv) begin
            s1_valid_d = accept;
            s1_sign_d  = A[W-1] ^ B[W-1];
            s1_nan_d   = a_nan || b_nan || inf_x_zero;
            s1_inv_d   = inf_x_zero;
            s1_inf_d   = a_inf || b_inf;
            s1_zero_d  = a_zero || b_zero;
            s1_rm_d    = rm;
            s1_exp_d   = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);
            s1_prod_d  = PW'({1'b1, man_a}) * PW'({1'b1, man_b});
        end
    end

    // Stage 2: normalise, round, range check
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_nan_d   = s2_nan_q;
        s2_inv_d   = s2_inv_q;
        s2_inf_d   = s2_inf_q;
        s2_zero_d  = s2_zero_q;
        s2_rm_d    = s2_rm_q;
        s2_ovf_d   = s2_ovf_q;
        s2_unf_d   = s2_unf_q;
        s2_inx_d   = s2_inx_q;
        s2_exp_d   = s2_exp_q;
        s2_man_d   = s2_man_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_nan_d   = s1_nan_q;
            s2_inv_d   = s1_inv_q;
            s2_inf_d   = s1_inf_q;
            s2_zero_d  = s1_zero_q;
            s2_rm_d    = s1_rm_q;
            s2_ovf_d   = ovf_c;
            s2_unf_d   = unf_c;
            s2_inx_d   = rnd_g || rnd_r || rnd_s;
            s2_exp_d   = exp_r[EXP_W-1:0];
            s2_man_d   = man_sum[MAN_W-1:0];
        end
    end

    // Stage 3: special-case select, pack, sticky flag accumulation
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_now_d = flags_now_q;
        if (adv) begin
            out_valid_d = s2_valid_q;
            if (s2_nan_q) begin
                out_d       = QNAN;
                flags_now_d = {s2_inv_q, 3'b000};
            end else if (s2_inf_q) begin
                out_d       = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_now_d = 4'b0000;
            end else if (s2_zero_q) begin
                out_d       = {s2_sign_q, {(W-1){1'b0}}};
                flags_now_d = 4'b0000;
            end else if (s2_ovf_q) begin
                out_d       = s2_rm_q ? {s2_sign_q, EXP_W'(EMAX - 1), {MAN_W{1'b1}}}
                                      : {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_now_d = 4'b0101;
            end else if (s2_unf_q) begin
                out_d       = {s2_sign_q, {(W-1){1'b0}}};
                flags_now_d = 4'b0011;
            end else begin
                out_d       = {s2_sign_q, s2_exp_q, s2_man_q};
                flags_now_d = {3'b000, s2_inx_q};
            end
        end
        // Clear wins over a same-cycle consume
        flags_d = flags_q;
        if (flag_clr) begin
            flags_d = 4'b0000;
        end else if (out_valid_q && out_ready) begin
            flags_d = flags_q | flags_now_q;
        end
    end

    // Pipeline and flag registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_rm_q     <= 1'b0;
            s1_exp_q    <= '0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_inv_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_rm_q     <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
            s2_inx_q    <= 1'b0;
            s2_exp_q    <= '0;
            s2_man_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_now_q <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_nan_q    <= s1_nan_d;
            s1_inv_q    <= s1_inv_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
            s1_rm_q     <= s1_rm_d;
            s1_exp_q    <= s1_exp_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_nan_q    <= s2_nan_d;
            s2_inv_q    <= s2_inv_d;
            s2_inf_q    <= s2_inf_d;
            s2_zero_q   <= s2_zero_d;
            s2_rm_q     <= s2_rm_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_unf_q    <= s2_unf_d;
            s2_inx_q    <= s2_inx_d;
            s2_exp_q    <= s2_exp_d;
            s2_man_q    <= s2_man_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_now_q <= flags_now_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags_now = flags_now_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (EXP_W=5, MAN_W=10): directed cases,
// backpressure stall, randomized operands vs an integer-arithmetic model,
// reset flush and flag-clear priority.
module tb_fp_mult_pipe;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned W     = 16;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         rm = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic [3:0]   flags_now;
    logic [3:0]   flags;
    logic         flag_clr = 1'b0;

    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags_now (flags_now),
        .flags     (flags),
        .flag_clr  (flag_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] o;
        logic [3:0]  f;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        r;
        logic [15:0] o;
        logic [3:0]  f;
    } dir_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] sticky_m = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: exact integer product, round by remainder vs half-ulp
    function automatic exp_t ref_mul(input logic [15:0] a, input logic [15:0] b, input logic r);
        exp_t   res;
        int     ea, eb, e, sh;
        longint p, q, rem, half;
        logic   s, an, bn, ai, bi, az, bz;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        an = (ea == 31) && (a[9:0] != 10'h0);
        bn = (eb == 31) && (b[9:0] != 10'h0);
        ai = (ea == 31) && (a[9:0] == 10'h0);
        bi = (eb == 31) && (b[9:0] == 10'h0);
        az = (ea == 0);
        bz = (eb == 0);
        res.f = 4'h0;
        res.o = 16'h0;
        if (an || bn) begin
            res.o = 16'h7E00;
            return res;
        end
        if ((ai && bz) || (bi && az)) begin
            res.o = 16'h7E00;
            res.f = 4'b1000;
            return res;
        end
        if (ai || bi) begin
            res.o = {s, 5'h1F, 10'h000};
            return res;
        end
        if (az || bz) begin
            res.o = {s, 15'h0000};
            return res;
        end
        p  = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
        e  = ea + eb - 15;
        sh = 10;
        if (p >= (longint'(1) << 21)) begin
            sh = 11;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem != 0) res.f[0] = 1'b1;
        if (!r && ((rem > half) || ((rem == half) && (q % 2 == 1)))) q++;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) begin
            res.f = 4'b0101;
            res.o = r ? {s, 5'h1E, 10'h3FF} : {s, 5'h1F, 10'h000};
        end else if (e <= 0) begin
            res.f = 4'b0011;
            res.o = {s, 15'h0000};
        end else begin
            res.o = {s, 5'(e), 10'(q - 1024)};
        end
        return res;
    endfunction

    function automatic logic [15:0] rand_fp();
        int          k;
        logic [15:0] v;
        k = $urandom_range(0, 19);
        v = 16'($urandom);
        if (k == 0)      v[14:10] = 5'h00;
        else if (k == 1) v[14:0]  = 15'h7C00;
        else if (k == 2) begin
            v[14:10] = 5'h1F;
            v[0]     = 1'b1;
        end
        else if (k <= 6) v[14:10] = 5'($urandom_range(24, 30));
        else if (k <= 9) v[14:10] = 5'($urandom_range(1, 7));
        else             v[14:10] = 5'($urandom_range(1, 30));
        return v;
    endfunction

    // Present one operation until accepted; expected result enters scoreboard on accept
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic r, input exp_t e);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done) begin
            @(posedge CLK);
            #1;
            in_valid = 1'b1;
            A = a;
            B = b;
            rm = r;
            @(negedge CLK);
            if (in_ready) begin
                sb_q.push_back(e);
                done = 1;
            end else if (++n > 200) begin
                total++;
                bad++;
                $display("FAIL issue_timeout: in_ready stuck low for %0d cycles", n);
                done = 1;
            end
        end
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge CLK);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results missing", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: pop and compare on every consumed result, check hold and sticky flags
    initial begin : monitor
        exp_t        e;
        logic        stalled;
        logic [15:0] hold_o;
        logic [3:0]  hold_f;
        stalled = 1'b0;
        hold_o  = 16'h0;
        hold_f  = 4'h0;
        forever begin
            @(negedge CLK);
            if (RESETn) begin
                check("sticky_flags", 32'(flags), 32'(sticky_m));
                if (stalled && out_valid) begin
                    check("hold_out", 32'(out), 32'(hold_o));
                    check("hold_flags_now", 32'(flags_now), 32'(hold_f));
                end
                if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'(0));
                stalled = out_valid && !out_ready;
                hold_o  = out;
                hold_f  = flags_now;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h with empty scoreboard", out);
                    end else begin
                        e = sb_q.pop_front();
                        check("out", 32'(out), 32'(e.o));
                        check("flags_now", 32'(flags_now), 32'(e.f));
                        sticky_m = flag_clr ? 4'h0 : (sticky_m | e.f);
                    end
                end else if (flag_clr) begin
                    sticky_m = 4'h0;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    dir_t dirs [0:11] = '{
        '{16'h3E00, 16'h4000, 1'b0, 16'h4200, 4'h0},
        '{16'h3C01, 16'h3C01, 1'b0, 16'h3C02, 4'h1},
        '{16'h3C01, 16'h3C01, 1'b1, 16'h3C02, 4'h1},
        '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5},
        '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, 4'h5},
        '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'h8},
        '{16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'h0},
        '{16'h0400, 16'h3800, 1'b0, 16'h0000, 4'h3},
        '{16'hFD00, 16'h3C00, 1'b0, 16'h7E00, 4'h0},
        '{16'h8000, 16'h3C00, 1'b0, 16'h8000, 4'h0},
        '{16'h0001, 16'h3C00, 1'b0, 16'h0000, 4'h0},
        '{16'h0001, 16'hFC00, 1'b1, 16'h7E00, 4'h8}
    };

    initial begin : main
        logic [15:0] ta, tb;
        logic        tr;
        int          lat, n;
        bit          rand_done;

        // Reset values
        RESETn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out", 32'(out), 32'(0));
        check("rst_flags_now", 32'(flags_now), 32'(0));
        check("rst_flags", 32'(flags), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        RESETn = 1'b1;

        // Latency of a single unstalled operation
        issue(16'h3E00, 16'h4000, 1'b0, '{16'h4200, 4'h0});
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(3));
        drain();

        // Directed table, back-to-back
        foreach (dirs[i]) issue(dirs[i].a, dirs[i].b, dirs[i].r, '{dirs[i].o, dirs[i].f});
        idle();
        drain();

        // Eight back-to-back ops with out_ready low for three cycles mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ta = {1'b0, 5'($urandom_range(10, 20)), 10'($urandom)};
                    tb = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
                    issue(ta, tb, 1'b0, ref_mul(ta, tb, 1'b0));
                end
                idle();
            end
            begin
                repeat (4) @(posedge CLK);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Randomized operands with random backpressure
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ta = rand_fp();
                    tb = rand_fp();
                    tr = 1'($urandom_range(0, 1));
                    issue(ta, tb, tr, ref_mul(ta, tb, tr));
                    if ($urandom_range(0, 7) == 0) idle();
                end
                idle();
                drain();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        @(posedge CLK);
        #1;
        out_ready = 1'b1;

        // Reset with two operations in flight
        issue(16'h3C01, 16'h3C01, 1'b0, '{16'h3C02, 4'h1});
        issue(16'h7BFF, 16'h7BFF, 1'b0, '{16'h7C00, 4'h5});
        idle();
        #1;
        RESETn = 1'b0;
        sb_q.delete();
        sticky_m = 4'h0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_flags", 32'(flags), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        repeat (6) @(posedge CLK);

        // Flag clear coincident with consuming an overflow result
        #1;
        out_ready = 1'b0;
        issue(16'h7BFF, 16'h7BFF, 1'b0, '{16'h7C00, 4'h5});
        idle();
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("clr_result_valid", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        flag_clr  = 1'b1;
        @(posedge CLK);
        #1;
        flag_clr = 1'b0;
        check("flag_clr_wins", 32'(flags), 32'(0));

        // Same result consumed without clear accumulates
        issue(16'h7BFF, 16'h7BFF, 1'b1, '{16'h7BFF, 4'h5});
        idle();
        drain();
        @(posedge CLK);
        #1;
        check("flags_accumulate", 32'(flags), 32'(4'h5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
